// File: rtl/mem_responder_pkg.sv
// Shared bus definitions for the memory responder: bus widths, I/O window
// base and register offsets, and the decoded-request / read-source types.
package mem_responder_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 32'h0003_0000;
    localparam logic [15:0]       IO_OFF_DATA     = 16'h0000;
    localparam logic [15:0]       IO_OFF_STAT     = 16'h0004;

    // Where the registered read byte comes from in the cycle after the access
    typedef enum logic [1:0] {
        RD_ZERO,
        RD_RAM,
        RD_IO
    } rd_src_e;

    typedef struct packed {
        logic        is_io;
        logic        wr;
        logic [15:0] off;
    } mem_req_t;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port byte RAM with synchronous read; a write returns the new byte.
module ram_byte_sync
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W_RAM = 17
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W_RAM-1:0] addr,
    input  logic [BYTE_W-1:0]     wdata,
    output logic [BYTE_W-1:0]     rdata
);

    logic [BYTE_W-1:0] mem [2**ADDR_W_RAM];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory responder: RAM plus a small I/O window with a UART TX FIFO,
// RX data/status register and a sticky halt flag.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int                RAM_ADDR_W = 17,
    parameter int                TX_DEPTH   = 16,
    parameter logic [ADDR_W-1:0] IO_BASE    = IO_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [BYTE_W-1:0] mem_wdata,
    output logic [BYTE_W-1:0] mem_rdata,
    output logic              io_buffer_full,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic              program_done,
    output logic              tx_overflow
);

    localparam int               PTR_W     = $clog2(TX_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(TX_DEPTH);
    localparam logic [CNT_W-1:0] NEAR_FULL = CNT_W'(TX_DEPTH - 2);

    mem_req_t          req;
    logic              ram_we;
    logic              push_req;
    logic              push_acc;
    logic              pop;
    logic              halt_wr;
    logic              io_data_rd;
    logic [BYTE_W-1:0] ram_rdata;
    logic [BYTE_W-1:0] io_q;
    rd_src_e           rd_src;

    logic [BYTE_W-1:0] fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    assign req.is_io = (mem_addr[31:16] == IO_BASE[31:16]);
    assign req.wr    = mem_wr;
    assign req.off   = mem_addr[15:0];

    assign ram_we     = !req.is_io && req.wr && !rst;
    assign push_req   = req.is_io && req.wr && (req.off == IO_OFF_DATA);
    assign halt_wr    = req.is_io && req.wr && (req.off == IO_OFF_STAT);
    assign io_data_rd = req.is_io && !req.wr && (req.off == IO_OFF_DATA);
    assign rx_pop     = io_data_rd && rx_valid && !rst;

    assign tx_valid       = (count != '0);
    assign tx_data        = fifo_mem[rd_ptr];
    assign io_buffer_full = (count >= NEAR_FULL);
    assign pop            = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign push_acc       = push_req && ((count != FULL_CNT) || pop) && !rst;

    ram_byte_sync #(
        .ADDR_W_RAM (RAM_ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (mem_addr[RAM_ADDR_W-1:0]),
        .wdata (mem_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_src <= RD_ZERO;
            io_q   <= '0;
        end else if (req.wr) begin
            rd_src <= RD_ZERO;
        end else if (req.is_io) begin
            rd_src <= RD_IO;
            if (req.off == IO_OFF_DATA)
                io_q <= rx_valid ? rx_data : '0;
            else if (req.off == IO_OFF_STAT)
                io_q <= {6'b0, rx_valid, io_buffer_full};
            else
                io_q <= '0;
        end else begin
            rd_src <= RD_RAM;
        end
    end

    always_comb begin
        mem_rdata = '0;
        case (rd_src)
            RD_RAM:  mem_rdata = ram_rdata;
            RD_IO:   mem_rdata = io_q;
            default: mem_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_acc)
            fifo_mem[wr_ptr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            tx_overflow  <= 1'b0;
            program_done <= 1'b0;
        end else begin
            if (push_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push_req && !push_acc)
                tx_overflow <= 1'b1;
            if (halt_wr)
                program_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// RAM and TX FIFO traffic checked against a queue/array reference model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_done;
    logic        tx_overflow;

    int checks = 0;
    int failures = 0;

    logic [7:0] ram_m [int];

    mem_responder dut (
        .clk            (clk),
        .rst            (rst),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .program_done   (program_done),
        .tx_overflow    (tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
        mem_wr    = wr;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        drive(1'b0, 32'h0, 8'h00);
        tx_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] ram_addr();
        logic [31:0] a;
        a = $urandom;
        if (a[31:16] == 16'h0003)
            a[31] = 1'b1;
        return a;
    endfunction

    task automatic test_reset;
        drive(1'b0, 32'h0, 8'h00);
        rst = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", mem_rdata); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (io_buffer_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", io_buffer_full); end
        checks++; if (rx_pop !== 1'b0) begin failures++; $display("FAIL reset_rx_pop got=%b exp=0", rx_pop); end
        checks++; if (program_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", program_done); end
        checks++; if (tx_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", tx_overflow); end
        rst = 1'b0;
    endtask

    task automatic test_ram_rw;
        drive(1'b1, 32'h0000_0010, 8'hA5);
        tick();
        ram_m['h10] = 8'hA5;
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL wr_cycle_rdata got=%h exp=00", mem_rdata); end
        drive(1'b0, 32'h0000_0010, 8'h00);
        tick();
        checks++; if (mem_rdata !== 8'hA5) begin failures++; $display("FAIL raw_a5 got=%h exp=a5", mem_rdata); end
    endtask

    task automatic test_burst_read;
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i), vals[i]);
            tick();
            ram_m['h100 + i] = vals[i];
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h100 + 32'(i), 8'h00);
            tick();
            checks++; if (mem_rdata !== vals[i]) begin failures++; $display("FAIL burst_rd%0d got=%h exp=%h", i, mem_rdata, vals[i]); end
        end
    endtask

    task automatic test_random_ram;
        logic [31:0] pool [8];
        logic [7:0]  d;
        logic [7:0]  exp;
        logic        wr;
        int          k;
        int          key;
        for (int i = 0; i < 8; i++) begin
            pool[i] = ram_addr();
            d = 8'($urandom);
            drive(1'b1, pool[i], d);
            tick();
            ram_m[int'(pool[i][16:0])] = d;
        end
        for (int n = 0; n < 60; n++) begin
            k   = $urandom_range(0, 7);
            wr  = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            key = int'(pool[k][16:0]);
            drive(wr, pool[k], d);
            tick();
            exp = wr ? 8'h00 : ram_m[key];
            if (wr)
                ram_m[key] = d;
            checks++; if (mem_rdata !== exp) begin failures++; $display("FAIL rand_ram n=%0d addr=%h got=%h exp=%h", n, pool[k], mem_rdata, exp); end
        end
    endtask

    task automatic test_rx;
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        drive(1'b0, 32'h0003_0000, 8'h00);
        #1;
        checks++; if (rx_pop !== 1'b1) begin failures++; $display("FAIL rx_pop_pulse got=%b exp=1", rx_pop); end
        tick();
        drive(1'b0, 32'h0, 8'h00);
        #1;
        checks++; if (mem_rdata !== 8'h5A) begin failures++; $display("FAIL rx_data got=%h exp=5a", mem_rdata); end
        checks++; if (rx_pop !== 1'b0) begin failures++; $display("FAIL rx_pop_once got=%b exp=0", rx_pop); end
        drive(1'b0, 32'h0003_0004, 8'h00);
        tick();
        checks++; if (mem_rdata !== 8'h02) begin failures++; $display("FAIL status_rx got=%h exp=02", mem_rdata); end
        rx_valid = 1'b0;
        drive(1'b0, 32'h0003_0000, 8'h00);
        #1;
        checks++; if (rx_pop !== 1'b0) begin failures++; $display("FAIL rx_nopop got=%b exp=0", rx_pop); end
        tick();
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL rx_empty got=%h exp=00", mem_rdata); end
        drive(1'b1, 32'h0003_0008, 8'hEE);
        tick();
        drive(1'b0, 32'h0003_0008, 8'h00);
        tick();
        checks++; if (mem_rdata !== 8'h00) begin failures++; $display("FAIL other_off got=%h exp=00", mem_rdata); end
        checks++; if (tx_valid !== 1'b0 || program_done !== 1'b0) begin failures++; $display("FAIL other_off_wr txv=%b done=%b exp=0/0", tx_valid, program_done); end
    endtask

    task automatic test_tx_fill;
        logic [7:0] q [$];
        logic [7:0] d;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            d = 8'($urandom);
            drive(1'b1, 32'h0003_0000, d);
            q.push_back(d);
            tick();
            checks++; if (io_buffer_full !== (i >= 14)) begin failures++; $display("FAIL fill_full push=%0d got=%b exp=%b", i, io_buffer_full, (i >= 14)); end
        end
        checks++; if (tx_overflow !== 1'b0) begin failures++; $display("FAIL fill_no_ovf got=%b exp=0", tx_overflow); end
        drive(1'b1, 32'h0003_0000, 8'hFF);
        tick();
        checks++; if (tx_overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", tx_overflow); end
        drive(1'b0, 32'h0, 8'h00);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== q[i]) begin failures++; $display("FAIL fill_drain%0d valid=%b got=%h exp=%h", i, tx_valid, tx_data, q[i]); end
            tick();
        end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_full_simul;
        logic [7:0] q [$];
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            drive(1'b1, 32'h0003_0000, d);
            q.push_back(d);
            tick();
        end
        d = 8'($urandom);
        drive(1'b1, 32'h0003_0000, d);
        tx_ready = 1'b1;
        #1;
        checks++; if (tx_data !== q[0]) begin failures++; $display("FAIL simul_head got=%h exp=%h", tx_data, q[0]); end
        tick();
        void'(q.pop_front());
        q.push_back(d);
        drive(1'b0, 32'h0, 8'h00);
        tx_ready = 1'b0;
        #1;
        checks++; if (tx_overflow !== 1'b0) begin failures++; $display("FAIL simul_no_ovf got=%b exp=0", tx_overflow); end
        checks++; if (io_buffer_full !== 1'b1) begin failures++; $display("FAIL simul_full got=%b exp=1", io_buffer_full); end
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++; if (tx_valid !== 1'b1 || tx_data !== q[i]) begin failures++; $display("FAIL simul_drain%0d valid=%b got=%h exp=%h", i, tx_valid, tx_data, q[i]); end
            tick();
        end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL simul_empty got=%b exp=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_tx_random;
        logic [7:0] q [$];
        logic [7:0] d;
        logic       push;
        logic       rdy;
        logic       pop;
        logic       ovf;
        do_reset();
        ovf = 1'b0;
        for (int n = 0; n < 240; n++) begin
            if (n < 120) begin
                push = ($urandom_range(0, 2) != 0);
                rdy  = ($urandom_range(0, 3) == 0);
            end else begin
                push = ($urandom_range(0, 3) == 0);
                rdy  = ($urandom_range(0, 3) != 0);
            end
            d = 8'($urandom);
            drive(push, push ? 32'h0003_0000 : 32'h0, d);
            tx_ready = rdy;
            #1;
            checks++; if (tx_valid !== (q.size() != 0)) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, tx_valid, (q.size() != 0)); end
            if (q.size() != 0) begin
                checks++; if (tx_data !== q[0]) begin failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, tx_data, q[0]); end
            end
            checks++; if (io_buffer_full !== (q.size() >= 14)) begin failures++; $display("FAIL rnd_full n=%0d got=%b exp=%b", n, io_buffer_full, (q.size() >= 14)); end
            checks++; if (tx_overflow !== ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, tx_overflow, ovf); end
            pop = (q.size() != 0) && rdy;
            if (push && q.size() == 16 && !pop)
                ovf = 1'b1;
            if (pop)
                void'(q.pop_front());
            if (push && !(q.size() == 16))
                q.push_back(d);
            tick();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_halt_reset;
        drive(1'b1, 32'h0003_0000, 8'h12);
        tick();
        drive(1'b1, 32'h0003_0004, 8'h00);
        tick();
        drive(1'b0, 32'h0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (program_done !== 1'b1) begin failures++; $display("FAIL halt_sticky%0d got=%b exp=1", i, program_done); end
        end
        // reset lands on a cycle that also carries a RAM write and a TX push
        drive(1'b1, 32'h0000_0010, 8'h77);
        rst = 1'b1;
        tick();
        drive(1'b1, 32'h0003_0000, 8'h99);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 8'h00);
        #1;
        checks++; if (program_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", program_done); end
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rst_txv got=%b exp=0", tx_valid); end
        checks++; if (io_buffer_full !== 1'b0 || tx_overflow !== 1'b0) begin failures++; $display("FAIL rst_flags full=%b ovf=%b exp=0/0", io_buffer_full, tx_overflow); end
        checks++; if (mem_rdata !== 8'h00 || rx_pop !== 1'b0) begin failures++; $display("FAIL rst_rd rdata=%h pop=%b exp=00/0", mem_rdata, rx_pop); end
        drive(1'b0, 32'h0000_0010, 8'h00);
        tick();
        checks++; if (mem_rdata !== ram_m['h10]) begin failures++; $display("FAIL rst_ram_kept got=%h exp=%h", mem_rdata, ram_m['h10]); end
    endtask

    initial begin
        rst = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        drive(1'b0, 32'h0, 8'h00);
        test_reset();
        test_ram_rw();
        test_burst_read();
        test_random_ram();
        test_rx();
        test_tx_fill();
        test_full_simul();
        test_tx_random();
        test_halt_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_ADDR_W, default 17, RAM byte-address width (128 KiB).
REQ-002 Parameter TX_DEPTH, default 16, UART transmit FIFO depth in bytes (power of two, >= 4).
REQ-003 Parameter IO_BASE, default 32'h0003_0000, base of the memory-mapped I/O window.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 mem_wr  in  1  1 = write, 0 = read; sampled every cycle.
REQ-007 mem_addr  in  32  byte address from the memory controller.
REQ-008 mem_wdata  in  8  write byte.
REQ-009 mem_rdata  out  8  read byte for the address presented the previous cycle.
REQ-010 io_buffer_full  out  1  TX FIFO nearly full; the controller stalls I/O writes.
REQ-011 tx_data  out  8  FIFO head byte toward the UART.
REQ-012 tx_valid  out  1  FIFO non-empty.
REQ-013 tx_ready  in  1  UART accepts tx_data this cycle.
REQ-014 rx_data  in  8  received byte from the UART.
REQ-015 rx_valid  in  1  rx_data holds an unread byte.
REQ-016 rx_pop  out  1  one-cycle pulse: rx byte consumed.
REQ-017 program_done  out  1  sticky; set by a halt write.
REQ-018 tx_overflow  out  1  sticky; a TX write was dropped.

Function
REQ-019 Decode: I/O access when mem_addr[31:16] == IO_BASE[31:16]; otherwise RAM access at mem_addr[RAM_ADDR_W-1:0], with upper bits ignored.
REQ-020 RAM write: when mem_wr=1 and the access is RAM, the byte at mem_wdata is stored at the rising edge.
REQ-021 Read latency: mem_rdata is registered and presents the data for cycle N's address during cycle N+1, with a throughput of one byte per cycle.
REQ-022 Read-after-write to the same address in consecutive cycles returns the newly written byte.
REQ-023 A write cycle updates mem_rdata to 8'h00.
REQ-024 I/O offset 0x0 write: push mem_wdata into the TX FIFO; if the FIFO is full, drop the byte and set tx_overflow.
REQ-025 I/O offset 0x0 read: if rx_valid, return rx_data next cycle and pulse rx_pop in the access cycle; otherwise return 8'h00 with no pop.
REQ-026 I/O offset 0x4 read: return {6'b0, rx_valid, io_buffer_full} sampled in the access cycle.
REQ-027 I/O offset 0x4 write: set program_done, which stays set until reset.
REQ-028 Other I/O offsets: reads return 8'h00 and writes have no effect.
REQ-029 The controller issues mem_wr=0, mem_addr=0 when idle; such a cycle is an ordinary RAM read of address 0 with no side effect.
REQ-030 TX FIFO: a transfer occurs when tx_valid and tx_ready are both high; the FIFO pops its head and tx_data shows the next byte in the following cycle.
REQ-031 A simultaneous push and pop leaves the count unchanged, including when the FIFO is full (the pop frees the slot, the push is accepted, no overflow).
REQ-032 Pointers wrap modulo TX_DEPTH; the count is kept 0..TX_DEPTH at log2(TX_DEPTH)+1 bits.
REQ-033 io_buffer_full = (count >= TX_DEPTH-2), combinational from registered count; this covers the controller's one-cycle reaction slack.
REQ-034 tx_valid = (count != 0); tx_data is don't-care while tx_valid = 0.

Reset
REQ-035 On rst, the following clear: mem_rdata=8'h00, FIFO pointers and count = 0, tx_valid=0, io_buffer_full=0, rx_pop=0, program_done=0, tx_overflow=0.
REQ-036 RAM contents are not cleared by rst.
REQ-037 rst asserted mid-operation discards FIFO contents and any pending read data, and suppresses that cycle's write and pop.

Structure
REQ-038 IO_BASE, the I/O offsets (0x0 data, 0x4 status/halt), and the byte/address bus widths belong in the shared definitions package alongside the controller's bus macros.
REQ-039 The RAM is a sub-module ram_byte_sync (single port, synchronous read, write-first); the FIFO stays inline.

Verification
REQ-040 Write 0xA5 @0x00010, then read 0x00010 next cycle -> mem_rdata=0xA5 one cycle after the read.
REQ-041 Four consecutive reads 0x100..0x103 after preload 11,22,33,44 -> mem_rdata 11,22,33,44 on cycles N+1..N+4.
REQ-042 With tx_ready=0, write 0x30000 with 16 bytes -> io_buffer_full rises after the 14th push; 16 bytes stored; a 17th write sets tx_overflow.
REQ-043 FIFO full, then simultaneous push and tx_ready=1 -> count stays 16, no overflow, bytes drain in FIFO order.
REQ-044 rx_valid=1, rx_data=0x5A, read 0x30000 -> rx_pop pulses once, mem_rdata=0x5A; with rx_valid=0 -> 0x00, no pulse.
REQ-045 Write 0x30004, then rst mid-stream -> program_done=1 until rst, then all outputs return to their reset values.
